// File: rtl/noc_inject_arbiter_pkg.sv
// Shared definitions for the NoC injection arbiter.
//  - Default parameter values for one PE-cluster-to-router instance.
//  - FSM state encoding (IDLE=0, LOCKED=1).
//  - Flit layout helpers: the CONNECT flit is {valid, is_tail, dest, vc, data}
//    with data in the least significant bits.
package noc_inject_arbiter_pkg;

  localparam int DEF_NUM_SRC         = 4;
  localparam int DEF_SRC_BITS        = 2;
  localparam int DEF_FLIT_DATA_WIDTH = 32;
  localparam int DEF_DEST_BITS       = 4;
  localparam int DEF_NUM_VCS         = 2;
  localparam int DEF_VC_BITS         = 1;
  localparam int DEF_CREDITS_PER_VC  = 8;
  localparam int DEF_CRED_BITS       = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Total flit width: valid + is_tail + dest + vc + data.
  function automatic int flit_width(input int dest_bits, input int vc_bits, input int data_bits);
    return 2 + dest_bits + vc_bits + data_bits;
  endfunction

  // Field offsets (LSB positions) within the flit.
  function automatic int vc_lsb(input int data_bits);
    return data_bits;
  endfunction

  function automatic int dest_lsb(input int vc_bits, input int data_bits);
    return data_bits + vc_bits;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_rr.sv
// Purely combinational round-robin picker.
//  req       in   N         request vector
//  ptr       in   IDX_BITS  last winner; scanning starts at ptr+1
//  grant     out  N         one-hot grant or zero
//  grant_idx out  IDX_BITS  index of the granted requester (0 when none)
//  any       out  1         at least one request present
module noc_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                any
);

  logic [IDX_BITS-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a value held and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IDX_BITS'((int'(ptr) + off) % N);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Injection arbiter sharing one router send port between NUM_SRC PE sources.
// Round-robin between packets, packet-atomic ownership, per-VC credit flow
// control, registered CONNECT flit output.
//  clk, rst_n       clock (rising) and asynchronous active-low reset
//  src_valid/tail   per-source flit present / flit is last of its packet
//  src_dest/vc/data flattened per-source fields (slice i belongs to source i)
//  src_ready        one-hot or zero, combinational: flit i taken this cycle
//  send_flit        registered {valid, is_tail, dest, vc, data}
//  credit_in_*      one credit returned by the router for a VC
//  grant_id         current or last owner
//  busy             high while a multi-flit packet holds the port
//  credit_err       sticky: a credit came back to an already-full counter
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int NUM_SRC         = DEF_NUM_SRC,
  parameter int SRC_BITS        = DEF_SRC_BITS,
  parameter int FLIT_DATA_WIDTH = DEF_FLIT_DATA_WIDTH,
  parameter int DEST_BITS       = DEF_DEST_BITS,
  parameter int NUM_VCS         = DEF_NUM_VCS,
  parameter int VC_BITS         = DEF_VC_BITS,
  parameter int CREDITS_PER_VC  = DEF_CREDITS_PER_VC,
  parameter int CRED_BITS       = DEF_CRED_BITS,
  localparam int FLIT_W         = flit_width(DEST_BITS, VC_BITS, FLIT_DATA_WIDTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_SRC-1:0]                 src_valid,
  input  logic [NUM_SRC-1:0]                 src_tail,
  input  logic [NUM_SRC*DEST_BITS-1:0]       src_dest,
  input  logic [NUM_SRC*VC_BITS-1:0]         src_vc,
  input  logic [NUM_SRC*FLIT_DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]                 src_ready,
  output logic [FLIT_W-1:0]                  send_flit,
  input  logic                               credit_in_valid,
  input  logic [VC_BITS-1:0]                 credit_in_vc,
  output logic [SRC_BITS-1:0]                grant_id,
  output logic                               busy,
  output logic                               credit_err
);

  localparam int NUM_VC_CODES = 1 << VC_BITS;

  state_t               state, state_nxt;
  logic [SRC_BITS-1:0]  owner, ptr, win;
  logic [VC_BITS-1:0]   lock_vc, fire_vc;
  logic                 fire;
  logic [CRED_BITS-1:0] credit [NUM_VCS];
  logic [NUM_VCS-1:0]   cred_dec, cred_inc;

  logic [DEST_BITS-1:0]       dest_of [NUM_SRC];
  logic [VC_BITS-1:0]         vc_of   [NUM_SRC];
  logic [FLIT_DATA_WIDTH-1:0] data_of [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      dest_of[i] = src_dest[i*DEST_BITS +: DEST_BITS];
      vc_of[i]   = src_vc[i*VC_BITS +: VC_BITS];
      data_of[i] = src_data[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
    end
  end

  // Per-VC-code "may send" flags. Codes at or above NUM_VCS have no counter
  // and are tied low, which keeps an out-of-range src_vc from ever firing.
  logic [NUM_VC_CODES-1:0] vc_avail;
  for (genvar k = 0; k < NUM_VC_CODES; k++) begin : g_vc_avail
    if (k < NUM_VCS) begin : g_real
      assign vc_avail[k] = (credit[k] != '0);
    end else begin : g_unused
      assign vc_avail[k] = 1'b0;
    end
  end

  logic [NUM_SRC-1:0]  elig_idle, rr_grant;
  logic [SRC_BITS-1:0] rr_idx;
  logic                rr_any;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      elig_idle[i] = src_valid[i] && vc_avail[vc_of[i]];
    end
  end

  noc_rr_arbiter #(
    .N        (NUM_SRC),
    .IDX_BITS (SRC_BITS)
  ) u_rr (
    .req       (elig_idle),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  // Fire decision and next state. While LOCKED the owner is the only
  // candidate and always sends on the VC captured with its head flit.
  // Gating with rst_n keeps src_ready low while reset is held, so no source
  // believes a flit was accepted that the reset then discards.
  always_comb begin
    fire      = 1'b0;
    win       = rr_idx;
    fire_vc   = vc_of[rr_idx];
    state_nxt = state;
    src_ready = '0;
    unique case (state)
      IDLE: begin
        if (rr_any && rst_n) begin
          fire      = 1'b1;
          state_nxt = src_tail[rr_idx] ? IDLE : LOCKED;
        end
      end
      LOCKED: begin
        win     = owner;
        fire_vc = lock_vc;
        if (src_valid[owner] && vc_avail[lock_vc] && rst_n) begin
          fire = 1'b1;
          if (src_tail[owner]) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (fire) src_ready[win] = 1'b1;
  end

  assign busy = (state == LOCKED);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      lock_vc   <= '0;
      ptr       <= SRC_BITS'(NUM_SRC - 1);
      grant_id  <= '0;
      send_flit <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        ptr       <= win;
        grant_id  <= win;
        send_flit <= {1'b1, src_tail[win], dest_of[win], fire_vc, data_of[win]};
        if (state == IDLE) begin
          owner   <= win;
          lock_vc <= fire_vc;
        end
      end else begin
        // Never present a stale flit to the router.
        send_flit <= '0;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      cred_dec[v] = fire && (fire_vc == VC_BITS'(v));
      cred_inc[v] = credit_in_valid && (credit_in_vc == VC_BITS'(v));
    end
  end

  // Credit counters: a simultaneous send and return on one VC cancel out.
  // A return into a full counter saturates and raises the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= CRED_BITS'(CREDITS_PER_VC);
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (cred_inc[v] && !cred_dec[v]) begin
          if (credit[v] == CRED_BITS'(CREDITS_PER_VC)) credit_err <= 1'b1;
          else                                          credit[v]  <= credit[v] + CRED_BITS'(1);
        end else if (cred_dec[v] && !cred_inc[v]) begin
          credit[v] <= credit[v] - CRED_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Bench for noc_inject_arbiter (defaults: 4 sources, 2 VCs, 8 credits/VC).
// Vector rows give per-cycle inputs plus the expected grant, VC and post-edge
// status. Source i drives dest = 3+row+i and data = 0xA5 + (row<<8) + i, so
// the expected flit is rebuilt from the expected winner. Expected post-edge
// values go into a queue when a row is driven and are popped after the edge.
module tb_noc_inject_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [3:0]   src_valid, src_tail, src_ready;
  logic [15:0]  src_dest;
  logic [3:0]   src_vc;
  logic [127:0] src_data;
  logic [38:0]  send_flit;
  logic         credit_in_valid, credit_in_vc;
  logic [1:0]   grant_id;
  logic         busy, credit_err;

  int checks = 0;
  int errors = 0;

  noc_inject_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_valid       (src_valid),
    .src_tail        (src_tail),
    .src_dest        (src_dest),
    .src_vc          (src_vc),
    .src_data        (src_data),
    .src_ready       (src_ready),
    .send_flit       (send_flit),
    .credit_in_valid (credit_in_valid),
    .credit_in_vc    (credit_in_vc),
    .grant_id        (grant_id),
    .busy            (busy),
    .credit_err      (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid, tail, vc;
    logic       cr_v, cr_vc;
    logic [3:0] e_ready;
    logic       e_vc;
    logic [1:0] e_gid;
    logic       e_busy, e_err;
  } vec_t;

  typedef struct {
    logic [38:0] flit;
    logic [1:0]  gid;
    logic        busy, err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic r, input logic [3:0] va, input logic [3:0] ta,
                              input logic [3:0] vc, input logic crv, input logic crvc,
                              input logic [3:0] er, input logic ev, input logic [1:0] eg,
                              input logic eb, input logic ee);
    vec_t v;
    v.rst = r; v.valid = va; v.tail = ta; v.vc = vc; v.cr_v = crv; v.cr_vc = crvc;
    v.e_ready = er; v.e_vc = ev; v.e_gid = eg; v.e_busy = eb; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    src_valid = '0; src_tail = '0; src_vc = '0; src_dest = '0; src_data = '0;
    credit_in_valid = 1'b0; credit_in_vc = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " send_flit"},  64'(send_flit),  64'd0);
    check({tag, " src_ready"},  64'(src_ready),  64'd0);
    check({tag, " busy"},       64'(busy),       64'd0);
    check({tag, " grant_id"},   64'(grant_id),   64'd0);
    check({tag, " credit_err"}, 64'(credit_err), 64'd0);
  endtask

  // Entered and left just after a rising edge.
  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive row k, check combinational src_ready, queue the
  // expected registered outputs, then compare them after the edge.
  task automatic run_cycle(input int k, input vec_t v);
    exp_t e, got;
    int   w;
    src_valid = v.valid;
    src_tail  = v.tail;
    src_vc    = v.vc;
    credit_in_valid = v.cr_v;
    credit_in_vc    = v.cr_vc;
    for (int i = 0; i < 4; i++) begin
      src_dest[i*4 +: 4]   = 4'(3 + k + i);
      src_data[i*32 +: 32] = 32'hA5 + 32'(k << 8) + 32'(i);
    end
    #3;
    check($sformatf("row%0d src_ready", k), 64'(src_ready), 64'(v.e_ready));
    w = -1;
    for (int i = 0; i < 4; i++) if (v.e_ready[i]) w = i;
    e.flit = '0;
    if (w >= 0)
      e.flit = {1'b1, v.tail[w], 4'(3 + k + w), v.e_vc, 32'hA5 + 32'(k << 8) + 32'(w)};
    e.gid  = v.e_gid;
    e.busy = v.e_busy;
    e.err  = v.e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (got.flit[38])
      check($sformatf("row%0d send_flit", k), 64'(send_flit), 64'(got.flit));
    else
      check($sformatf("row%0d flit_valid", k), 64'(send_flit[38]), 64'd0);
    check($sformatf("row%0d grant_id", k),   64'(grant_id),   64'(got.gid));
    check($sformatf("row%0d busy", k),       64'(busy),       64'(got.busy));
    check($sformatf("row%0d credit_err", k), 64'(credit_err), 64'(got.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst, valid, tail, vc, cr_v, cr_vc, e_ready, e_vc, e_gid, e_busy, e_err
    // single-flit packet from src0 (dest 3, data A5)
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 2'd0, 0, 0));
    // all sources, single-flit packets: order 0,1,2,3,0 with no idle cycle
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1010, 0, 0, 4'b0001, 0, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 0, 0, 4'b0010, 1, 2'd1, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 0, 0, 4'b0100, 0, 2'd2, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 0, 0, 4'b1000, 1, 2'd3, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 0, 0, 4'b0001, 0, 2'd0, 0, 0));
    // src1 3-flit packet on vc1 while src2 waits; body flits keep lock_vc
    vecs.push_back(mk(0, 4'b0110, 4'b0100, 4'b0010, 0, 0, 4'b0010, 1, 2'd1, 1, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0100, 4'b0000, 0, 0, 4'b0010, 1, 2'd1, 1, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0110, 4'b0000, 0, 0, 4'b0010, 1, 2'd1, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 4'b0100, 0, 2'd2, 0, 0));
    // owner src0 goes idle mid-packet: port stalls, src2 is not preempting
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 2'd0, 1, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 1, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 4'b0100, 0, 2'd2, 0, 0));
    // vc1 exhaustion: 8 sends, stall, vc0 still served, one return resumes
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 0, 0, 4'b1000, 1, 2'd3, 0, 0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 0, 0, 4'b1000, 1, 2'd3, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 0, 0, 4'b0000, 0, 2'd3, 0, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 4'b1000, 0, 0, 4'b0001, 0, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 1, 1, 4'b0000, 0, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 0, 0, 4'b1000, 1, 2'd3, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 0, 0, 4'b0000, 0, 2'd3, 0, 0));
    // vc0: send (7), send+return (7), return (8), return at full -> sticky err
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 4'b0001, 0, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 2'd0, 0, 1));

    zero_inputs();
    @(posedge clk);
    #1;
    do_reset();

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) do_reset();
      run_cycle(k, vecs[k]);
    end

    // Reset in the middle of a 4-flit packet from src2 on vc1.
    do_reset();
    run_cycle(50, mk(0, 4'b0100, 4'b0000, 4'b0100, 0, 0, 4'b0100, 1, 2'd2, 1, 0));
    run_cycle(51, mk(0, 4'b0100, 4'b0000, 4'b0100, 0, 0, 4'b0100, 1, 2'd2, 1, 0));
    src_valid = 4'b0101;
    src_tail  = 4'b0000;
    src_vc    = 4'b0100;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-packet async reset");
    @(posedge clk);
    #1;
    check_reset_outputs("mid-packet reset held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Back in IDLE with source 0 first, then src2 as a fresh single-flit packet.
    run_cycle(52, mk(0, 4'b0101, 4'b0101, 4'b0100, 0, 0, 4'b0001, 0, 2'd0, 0, 0));
    run_cycle(53, mk(0, 4'b0100, 4'b0100, 4'b0100, 0, 0, 4'b0100, 1, 2'd2, 0, 0));

    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
